skid_pipe: RTL and testbench
============================

Name: skid_pipe

Overview:
- Full-throughput valid/ready register slice chain, STAGES deep.
- Each stage registers the forward path (valid/data) and the backward path (ready), so no combinational path runs from dout_ready to din_ready or from din_* to dout_*.
- Complements the single-register decouple, which registers only the forward path and runs at half rate. Placed between gears to close timing on long ready chains without losing bandwidth.

Parameters:
- STAGES, 1, number of cascaded skid stages (>=1); latency STAGES cycles, capacity 2*STAGES words.
- DIN, 16, data width in bits.
- INIT, 0, data value preloaded into the output stage main register at reset when INIT_VALID=1.
- INIT_VALID, 0, 1: output stage holds one valid INIT word after reset.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din_ready  output  1  upstream ready, driven from a register of stage 0.
- din_valid  input  1  upstream valid.
- din_data  input  DIN  upstream data.
- dout_ready  input  1  downstream ready.
- dout_valid  output  1  downstream valid, driven from a register of the last stage.
- dout_data  output  DIN  downstream data, driven from a register of the last stage.

Behaviour:
- Stage k has a main register (m_valid, m_data) and a skid register (s_valid, s_data).
  - Upstream of stage 0 is din_*; upstream of stage k>0 is stage k-1 main.
  - Downstream of the last stage is dout_*.
  - up_ready(k) = ~s_valid(k) & ~rst_done_n, i.e. a function of registers only.
- Stage states, derived from (m_valid, s_valid):
  - EMPTY (0,0): up_ready=1. Upstream transfer loads main -> BUSY.
  - BUSY (1,0): up_ready=1.
    - in & out: main <= in, stay BUSY.
    - in & ~out: skid <= in -> FULL.
    - ~in & out -> EMPTY.
  - FULL (1,1): up_ready=0. out: main <= skid, skid invalid -> BUSY. ~out: hold.
  - (0,1) is unreachable; a checker flags it.
- Transfers: in = up_valid & up_ready; out = m_valid & down_ready. Data changes only on a transfer.
- Latency: a word accepted at edge N appears on dout at edge N+STAGES when nothing is blocked.
- Throughput: 1 word/cycle sustained.
- Backpressure:
  - After dout_ready falls, din_ready falls at the earliest 1 cycle per stage later.
  - No word is dropped or duplicated; up to 2*STAGES words are held.
- Ordering: strict FIFO.
- Reset (async assert, registers cleared immediately):
  - All m_valid, s_valid = 0; dout_valid = 0.
  - Exception: if INIT_VALID=1, last stage m_valid=1 and m_data=INIT.
  - din_ready = 0 while rst is high. It rises on the first clk edge after release, via a registered rst_done flag.
- Reset mid-operation discards all in-flight words; no partial output follows reset release.
- Simultaneous dout_ready and din_valid in the FULL state: the stage drains skid into main; the upstream word is not accepted that cycle.
- dout_valid, once high, stays high with stable dout_data until dout_ready is sampled high (AXI-style rule).

Optional Feature:
- Macro: SKID_PIPE_LEVEL_EN.
- Defined: adds output port level, width $clog2(2*STAGES+1).
  - Registered count of words held across all stages.
  - +1 on a din transfer, -1 on a dout transfer, unchanged when both occur.
  - Resets to INIT_VALID.
- Undefined: no level port and no counter logic.

Test Plan:
- Streaming, STAGES=2, DIN=16, dout_ready=1: din 0x0001..0x0064 valid every cycle -> dout 0x0001..0x0064 in order, first word 2 cycles after acceptance, no bubbles, din_ready stays 1.
- Backpressure fill, STAGES=2: dout_ready=0, din_valid=1 continuously -> exactly 4 words accepted, then din_ready=0. Raise dout_ready -> 4 words out in order, din_ready back to 1 within 2 cycles.
- Random valid/ready at 50%, STAGES=3, 10k words: scoreboard matches exactly, dout stable while stalled, state (0,1) never seen.
- Reset mid-operation: 3 words held, assert rst asynchronously mid-cycle -> dout_valid=0 and din_ready=0 immediately. After release, din_ready=1 on the next edge and no stale word emerges.
- INIT_VALID=1, INIT=0xABCD: after reset release with dout_ready=1 -> first dout is 0xABCD, then the streamed words.
- SKID_PIPE_LEVEL_EN, STAGES=2: fill 4 with dout blocked -> level=4. Simultaneous in/out -> level unchanged. Drain -> level=0.

Source files
------------

// File: rtl/skid_pipe.sv
// skid_pipe: STAGES-deep chain of full-throughput valid/ready skid slices (registered forward and backward paths).
// Optional SKID_PIPE_LEVEL_EN adds a registered 'level' output counting words held across the chain.
module skid_pipe #(
  parameter int             STAGES     = 1,
  parameter int             DIN        = 16,
  parameter logic [DIN-1:0] INIT       = '0,
  parameter bit             INIT_VALID = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  output logic           din_ready,
  input  logic           din_valid,
  input  logic [DIN-1:0] din_data,
  input  logic           dout_ready,
  output logic           dout_valid,
  output logic [DIN-1:0] dout_data
`ifdef SKID_PIPE_LEVEL_EN
  ,
  output logic [$clog2(2*STAGES+1)-1:0] level
`endif
);

  logic           rst_done;
  logic           m_valid    [STAGES];
  logic           s_valid    [STAGES];
  logic [DIN-1:0] m_data     [STAGES];
  logic [DIN-1:0] s_data     [STAGES];
  logic           up_valid   [STAGES];
  logic [DIN-1:0] up_data    [STAGES];
  logic           up_ready   [STAGES];
  logic           down_ready [STAGES];

  // Holds every stage closed to upstream until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_done <= 1'b0;
    else     rst_done <= 1'b1;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam bit             RST_MV = (k == STAGES-1) ? INIT_VALID : 1'b0;
    localparam logic [DIN-1:0] RST_MD = (k == STAGES-1) ? INIT : '0;

    logic in_xfer;

    assign up_ready[k] = ~s_valid[k] & rst_done;
    assign in_xfer     = up_valid[k] & up_ready[k];

    if (k == 0) begin : g_head
      assign up_valid[k] = din_valid;
      assign up_data[k]  = din_data;
    end else begin : g_link
      assign up_valid[k] = m_valid[k-1];
      assign up_data[k]  = m_data[k-1];
    end

    if (k == STAGES-1) begin : g_tail
      assign down_ready[k] = dout_ready;
    end else begin : g_mid
      assign down_ready[k] = up_ready[k+1];
    end

    // FULL drains skid into main; a stalled BUSY parks the incoming word in skid;
    // otherwise main simply follows the upstream transfer.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        m_valid[k] <= RST_MV;
        m_data[k]  <= RST_MD;
        s_valid[k] <= 1'b0;
        s_data[k]  <= '0;
      end else if (s_valid[k]) begin
        if (down_ready[k]) begin
          m_data[k]  <= s_data[k];
          s_valid[k] <= 1'b0;
        end
      end else if (m_valid[k] && !down_ready[k]) begin
        if (in_xfer) begin
          s_data[k]  <= up_data[k];
          s_valid[k] <= 1'b1;
        end
      end else begin
        m_valid[k] <= in_xfer;
        if (in_xfer) m_data[k] <= up_data[k];
      end
    end

    a_no_skid_only: assert property (@(posedge clk) disable iff (rst) !(s_valid[k] && !m_valid[k]));
  end

  assign din_ready  = up_ready[0];
  assign dout_valid = m_valid[STAGES-1];
  assign dout_data  = m_data[STAGES-1];

`ifdef SKID_PIPE_LEVEL_EN
  localparam int LW = $clog2(2*STAGES+1);

  logic din_xfer;
  logic dout_xfer;

  assign din_xfer  = din_valid & din_ready;
  assign dout_xfer = dout_valid & dout_ready;

  // Occupancy tracks only the chain's boundary transfers; internal moves do not change it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        level <= LW'(INIT_VALID);
    else if (din_xfer && !dout_xfer) level <= level + LW'(1);
    else if (!din_xfer && dout_xfer) level <= level - LW'(1);
  end
`endif

endmodule

// File: tb/tb_skid_pipe.sv
// tb_skid_pipe: drives three skid_pipe builds (2 stages, 3 stages, 2 stages with INIT word) from shared
// stimulus and checks each against its own FIFO reference model.
module tb_skid_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din_valid = 1'b0;
  logic [15:0] din_data = '0;
  logic        dout_ready = 1'b0;
  logic [2:0]  din_ready;
  logic [2:0]  dout_valid;
  logic [15:0] dout_data [3];
`ifdef SKID_PIPE_LEVEL_EN
  logic [2:0]  level [3];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit check_lat = 1'b0;

  logic [15:0] mdata [3][64];
  int          macc  [3][64];
  int          head [3];
  int          tail [3];
  int          acc_count [3];
  bit          stalled [3];
  logic [15:0] stall_data [3];

  always #5 clk = ~clk;

  skid_pipe #(.STAGES(2), .DIN(16)) u_s2 (
    .clk(clk), .rst(rst),
    .din_ready(din_ready[0]), .din_valid(din_valid), .din_data(din_data),
    .dout_ready(dout_ready), .dout_valid(dout_valid[0]), .dout_data(dout_data[0])
`ifdef SKID_PIPE_LEVEL_EN
    , .level(level[0])
`endif
  );

  skid_pipe #(.STAGES(3), .DIN(16)) u_s3 (
    .clk(clk), .rst(rst),
    .din_ready(din_ready[1]), .din_valid(din_valid), .din_data(din_data),
    .dout_ready(dout_ready), .dout_valid(dout_valid[1]), .dout_data(dout_data[1])
`ifdef SKID_PIPE_LEVEL_EN
    , .level(level[1])
`endif
  );

  skid_pipe #(.STAGES(2), .DIN(16), .INIT(16'hABCD), .INIT_VALID(1'b1)) u_init (
    .clk(clk), .rst(rst),
    .din_ready(din_ready[2]), .din_valid(din_valid), .din_data(din_data),
    .dout_ready(dout_ready), .dout_valid(dout_valid[2]), .dout_data(dout_data[2])
`ifdef SKID_PIPE_LEVEL_EN
    , .level(level[2])
`endif
  );

  function automatic int stages(input int i);
    return (i == 1) ? 3 : 2;
  endfunction

  function automatic int initv(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  function automatic int occ(input int i);
    return tail[i] - head[i];
  endfunction

  // Checks one cycle's outputs at posedge+1 against the models, then advances one clock.
  task automatic cycle();
    bit          inx;
    bit          outx;
    logic [15:0] exp;
    for (int i = 0; i < 3; i++) begin
      inx  = din_valid && (din_ready[i] === 1'b1);
      outx = (dout_valid[i] === 1'b1) && dout_ready;
      if (stalled[i]) begin
        checks++;
        if (dout_valid[i] !== 1'b1 || dout_data[i] !== stall_data[i]) begin
          errors++;
          $display("[TB] FAIL stable_dut%0d: valid=%b data=%h required valid=1 data=%h",
                   i, dout_valid[i], dout_data[i], stall_data[i]);
        end
      end
`ifdef SKID_PIPE_LEVEL_EN
      checks++;
      if (level[i] !== 3'(occ(i))) begin
        errors++;
        $display("[TB] FAIL level_dut%0d: got %0d required %0d", i, level[i], occ(i));
      end
`endif
      if (outx) begin
        checks++;
        if (head[i] == tail[i]) begin
          errors++;
          $display("[TB] FAIL phantom_dut%0d: got word %h required none", i, dout_data[i]);
        end else begin
          exp = mdata[i][head[i] % 64];
          if (dout_data[i] !== exp) begin
            errors++;
            $display("[TB] FAIL order_dut%0d: got %h required %h", i, dout_data[i], exp);
          end
          if (check_lat && macc[i][head[i] % 64] >= 0) begin
            checks++;
            if (cyc - macc[i][head[i] % 64] != stages(i)) begin
              errors++;
              $display("[TB] FAIL latency_dut%0d: got %0d required %0d",
                       i, cyc - macc[i][head[i] % 64], stages(i));
            end
          end
          head[i]++;
        end
      end
      if (inx) begin
        mdata[i][tail[i] % 64] = din_data;
        macc[i][tail[i] % 64]  = cyc;
        tail[i]++;
        acc_count[i]++;
      end
      checks++;
      if (occ(i) > 2*stages(i)) begin
        errors++;
        $display("[TB] FAIL capacity_dut%0d: holds %0d required at most %0d", i, occ(i), 2*stages(i));
      end
      stalled[i]    = (dout_valid[i] === 1'b1) && !dout_ready;
      stall_data[i] = dout_data[i];
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asserts rst away from any clock edge, checks the reset state, and releases it asynchronously.
  task automatic do_reset();
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (din_ready[i] !== 1'b0 || dout_valid[i] !== 1'(initv(i))) begin
        errors++;
        $display("[TB] FAIL reset_dut%0d: din_ready=%b dout_valid=%b required 0 and %0d",
                 i, din_ready[i], dout_valid[i], initv(i));
      end
`ifdef SKID_PIPE_LEVEL_EN
      checks++;
      if (level[i] !== 3'(initv(i))) begin
        errors++;
        $display("[TB] FAIL reset_level_dut%0d: got %0d required %0d", i, level[i], initv(i));
      end
`endif
    end
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (din_ready[i] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL release_dut%0d: din_ready=%b required 0", i, din_ready[i]);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (din_ready[i] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ready_rise_dut%0d: din_ready=%b required 1", i, din_ready[i]);
      end
      head[i] = 0;
      tail[i] = 0;
      acc_count[i] = 0;
      stalled[i] = 1'b0;
      if (initv(i) == 1) begin
        mdata[i][0] = 16'hABCD;
        macc[i][0]  = -1;
        tail[i]     = 1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    while ((occ(0) + occ(1) + occ(2)) != 0 && n < 50) begin
      cycle();
      n++;
    end
    for (int k = 0; k < 3; k++) cycle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (occ(i) != 0) begin
        errors++;
        $display("[TB] FAIL drain_dut%0d: %0d words still expected, required 0", i, occ(i));
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 4; k++) cycle();
  endtask

  task automatic test_streaming();
    do_reset();
    check_lat  = 1'b1;
    dout_ready = 1'b1;
    for (int w = 1; w <= 100; w++) begin
      din_valid = 1'b1;
      din_data  = 16'(w);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (din_ready[i] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stream_ready_dut%0d: word %0d din_ready=%b required 1", i, w, din_ready[i]);
        end
      end
      cycle();
    end
    drain();
    check_lat = 1'b0;
  endtask

  task automatic test_backpressure();
    int t0;
    int rise [3];
    do_reset();
    dout_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      din_valid = 1'b1;
      din_data  = 16'($urandom);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc_count[i] != 2*stages(i) - initv(i) || din_ready[i] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fill_dut%0d: accepted %0d din_ready=%b required %0d and 0",
                 i, acc_count[i], din_ready[i], 2*stages(i) - initv(i));
      end
      rise[i] = -1;
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 3; i++)
        if (rise[i] < 0 && din_ready[i] === 1'b1) rise[i] = cyc;
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rise[i] < 0 || rise[i] - t0 > stages(i)) begin
        errors++;
        $display("[TB] FAIL recover_dut%0d: din_ready rose after %0d cycles required at most %0d",
                 i, rise[i] - t0, stages(i));
      end
    end
    drain();
  endtask

  task automatic test_random();
    int n;
    do_reset();
    n = 0;
    while (acc_count[1] < 10000 && n < 60000) begin
      din_valid  = 1'($urandom_range(0, 1));
      din_data   = 16'($urandom);
      dout_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    checks++;
    if (acc_count[1] != 10000) begin
      errors++;
      $display("[TB] FAIL random_budget: accepted %0d required 10000", acc_count[1]);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    do_reset();
    dout_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din_valid = 1'b1;
      din_data  = 16'h5000 + 16'(k);
      cycle();
    end
    din_valid = 1'b0;
    cycle();
    do_reset();
    drain();
  endtask

  task automatic test_init();
    do_reset();
    checks++;
    if (dout_valid[2] !== 1'b1 || dout_data[2] !== 16'hABCD) begin
      errors++;
      $display("[TB] FAIL init_word: valid=%b data=%h required 1 and abcd", dout_valid[2], dout_data[2]);
    end
    dout_ready = 1'b1;
    for (int w = 0; w < 6; w++) begin
      din_valid = 1'b1;
      din_data  = 16'h0100 + 16'(w);
      cycle();
    end
    drain();
  endtask

`ifdef SKID_PIPE_LEVEL_EN
  task automatic test_level();
    do_reset();
    dout_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      din_valid = 1'b1;
      din_data  = 16'($urandom);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (level[i] !== 3'(2*stages(i))) begin
        errors++;
        $display("[TB] FAIL level_full_dut%0d: got %0d required %0d", i, level[i], 2*stages(i));
      end
    end
    dout_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      din_valid = 1'b1;
      din_data  = 16'($urandom);
      cycle();
    end
    drain();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (level[i] !== 3'd0) begin
        errors++;
        $display("[TB] FAIL level_empty_dut%0d: got %0d required 0", i, level[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_mid_reset();
    test_init();
    test_random();
`ifdef SKID_PIPE_LEVEL_EN
    test_level();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
